// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared types for the EX->MEM boundary.
// Payload layout, flag indices, skid states.
package ex_mem_skid_stage_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int REG_W_DEFAULT = 4;

  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef struct packed {
    logic [N_DEFAULT-1:0]     result;
    logic [REG_W_DEFAULT-1:0] rd;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic [N_DEFAULT-1:0]     store_data;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic int payload_w(int n, int reg_w);
    return 2 * n + reg_w + 3;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_skid_buffer.sv
// Generic 2-entry valid/ready skid register.
// in_ready decodes registered state only.
module skid_buffer
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = head_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO-ordered head/skid update; flush drops all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept && !pop: begin
              skid_q  <= in_data;
              state_q <= FULL;
            end
            accept && pop: begin
              head_q <= in_data;
            end
            pop && !accept: begin
              state_q <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM boundary: skid buffer, NZCV flags,
// and head-entry forwarding tap.
module ex_mem_skid_stage
  import ex_mem_skid_stage_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic [3:0]       in_flags,
  input  logic             in_flags_en,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic [N-1:0]     in_store_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [REG_W-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [N-1:0]     out_store_data,
  output logic [3:0]       flags_q,
  output logic             fwd_valid,
  output logic [REG_W-1:0] fwd_rd,
  output logic [N-1:0]     fwd_result
);

  localparam int PW = payload_w(N, REG_W);

  logic [PW-1:0] in_pl;
  logic [PW-1:0] head_pl;
  logic          accept;

  assign in_pl = {in_result, in_rd, in_reg_write,
                  in_mem_read, in_mem_write,
                  in_store_data};

  skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_pl)
  );

  assign {out_result, out_rd, out_reg_write,
          out_mem_read, out_mem_write,
          out_store_data} = head_pl;

  assign accept     = in_valid && in_ready;
  assign fwd_valid  = out_valid && out_reg_write;
  assign fwd_rd     = out_rd;
  assign fwd_result = out_result;

  // Flags commit at the edge that captures the op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (accept && in_flags_en && !flush) begin
      flags_q <= in_flags;
    end
  end

  // Load+store on one op is illegal upstream.
  a_no_ld_st : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_valid && in_mem_read && in_mem_write)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage.
// Table vectors plus multi-cycle sequences.
module tb_ex_mem_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [3:0] in_flags;
  logic       in_flags_en;
  logic [3:0] in_rd;
  logic       in_reg_write;
  logic       in_mem_read;
  logic       in_mem_write;
  logic [7:0] in_store_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_rd;
  logic       out_reg_write;
  logic       out_mem_read;
  logic       out_mem_write;
  logic [7:0] out_store_data;
  logic [3:0] flags_q;
  logic       fwd_valid;
  logic [3:0] fwd_rd;
  logic [7:0] fwd_result;

  int checks = 0;
  int failures = 0;

  ex_mem_skid_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_flags       (in_flags),
    .in_flags_en    (in_flags_en),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_store_data  (in_store_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_store_data (out_store_data),
    .flags_q        (flags_q),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_result     (fwd_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] res;
    logic [7:0] sd;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [3:0] fl;
    logic       fen;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_res;
    logic [7:0] e_sd;
    logic [3:0] e_rd;
    logic       e_mr;
    logic       e_mw;
    logic       e_ir;
    logic [3:0] e_fq;
    logic       e_fwv;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v,
                     input logic [7:0] res,
                     input logic [3:0] fl,
                     input logic fen,
                     input logic ordy);
    in_valid      = v;
    in_result     = res;
    in_flags      = fl;
    in_flags_en   = fen;
    in_rd         = 4'd0;
    in_reg_write  = 1'b1;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_store_data = 8'h00;
    out_ready     = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1, 8'd5,   8'hA5, 4'd1, 1, 0, 1,
               4'b1000, 1, 1,
               1, 8'd5,   8'hA5, 4'd1, 0, 1,
               1, 4'b1000, 1};
    tbl[1] = '{1, 8'hFD,  8'h3C, 4'd2, 1, 1, 0,
               4'b0100, 0, 1,
               1, 8'hFD,  8'h3C, 4'd2, 1, 0,
               1, 4'b1000, 1};
    tbl[2] = '{1, 8'd0,   8'h00, 4'd3, 0, 0, 0,
               4'b0110, 1, 1,
               1, 8'd0,   8'h00, 4'd3, 0, 0,
               1, 4'b0110, 0};
    tbl[3] = '{0, 8'd77,  8'h00, 4'd9, 1, 0, 0,
               4'b1111, 1, 1,
               0, 8'd0,   8'h00, 4'd0, 0, 0,
               1, 4'b0110, 0};
    tbl[4] = '{1, 8'd7,   8'h11, 4'd4, 1, 0, 0,
               4'b0000, 0, 0,
               1, 8'd7,   8'h11, 4'd4, 0, 0,
               1, 4'b0110, 1};
    tbl[5] = '{1, 8'd8,   8'h22, 4'd6, 1, 0, 0,
               4'b0000, 0, 1,
               1, 8'd8,   8'h22, 4'd6, 0, 0,
               1, 4'b0110, 1};
    tbl[6] = '{0, 8'd0,   8'h00, 4'd0, 0, 0, 0,
               4'b0000, 0, 1,
               0, 8'd0,   8'h00, 4'd0, 0, 0,
               1, 4'b0110, 0};

    rst_n = 1'b0;
    flush = 1'b0;
    drv(1, 8'd42, 4'hF, 1, 1);
    in_rd = 4'd5;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flags", flags_q, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
    end

    rst_n = 1'b1;
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_result", out_result, 42);
    chk("first_fwd_rd", fwd_rd, 5);
    chk("first_flags", flags_q, 4'hF);

    for (int i = 0; i < 7; i++) begin
      in_valid      = tbl[i].v;
      in_result     = tbl[i].res;
      in_store_data = tbl[i].sd;
      in_rd         = tbl[i].rd;
      in_reg_write  = tbl[i].rw;
      in_mem_read   = tbl[i].mr;
      in_mem_write  = tbl[i].mw;
      in_flags      = tbl[i].fl;
      in_flags_en   = tbl[i].fen;
      out_ready     = tbl[i].ordy;
      tick();
      chk($sformatf("v%0d_out_valid", i),
          out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_in_ready", i),
          in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_flags", i),
          flags_q, tbl[i].e_fq);
      chk($sformatf("v%0d_fwd_valid", i),
          fwd_valid, tbl[i].e_fwv);
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_result", i),
            out_result, tbl[i].e_res);
        chk($sformatf("v%0d_store", i),
            out_store_data, tbl[i].e_sd);
        chk($sformatf("v%0d_rd", i),
            out_rd, tbl[i].e_rd);
        chk($sformatf("v%0d_mem_read", i),
            out_mem_read, tbl[i].e_mr);
        chk($sformatf("v%0d_mem_write", i),
            out_mem_write, tbl[i].e_mw);
        chk($sformatf("v%0d_fwd_rd", i),
            fwd_rd, tbl[i].e_rd);
        chk($sformatf("v%0d_fwd_res", i),
            fwd_result, tbl[i].e_res);
      end
    end

    drv(1, 8'd10, 4'h0, 0, 0);
    tick();
    chk("bp1_valid", out_valid, 1);
    chk("bp1_result", out_result, 10);
    chk("bp1_ready", in_ready, 1);
    drv(1, 8'd20, 4'h0, 0, 0);
    tick();
    chk("bp2_result", out_result, 10);
    chk("bp2_ready", in_ready, 0);
    drv(1, 8'd30, 4'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 10);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_result", out_result, 20);
    chk("bp_pop1_ready", in_ready, 1);
    tick();
    chk("bp_pop2_valid", out_valid, 1);
    chk("bp_pop2_result", out_result, 30);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_ready", in_ready, 1);

    drv(1, 8'd11, 4'h0, 0, 0);
    tick();
    drv(1, 8'd12, 4'h0, 0, 0);
    tick();
    chk("fl_full_ready", in_ready, 0);
    drv(1, 8'd99, 4'b0001, 1, 0);
    flush = 1'b1;
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_flags_kept", flags_q, 4'b0110);
    flush = 1'b0;
    drv(0, 8'd0, 4'h0, 0, 1);
    tick();
    chk("fl_after_valid", out_valid, 0);
    chk("fl_after_ready", in_ready, 1);
    drv(1, 8'd13, 4'h0, 0, 1);
    tick();
    chk("fl_new_valid", out_valid, 1);
    chk("fl_new_result", out_result, 13);
    in_valid = 1'b0;
    tick();
    chk("fl_new_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
